// File: rtl/mem_arbiter.sv
// mem_arbiter
// Shares a single mem_system request port between an instruction port (I)
// and a data port (D). An idle arbiter forwards the winning request straight
// through in the same cycle, so a grant costs no latency. A transaction that
// does not finish in its grant cycle is owned until memDone, with the request
// fields replayed from a latch. D normally wins a tie, but after MAX_CONSEC
// back-to-back D grants taken while I was waiting, I gets the next grant.
//
// Ports
//   clk, rst                      clock, synchronous active-high reset
//   iAddr/iDataIn/iRd/iWr         I-port request
//   iDataOut/iDone/iStall/iCacheHit  I-port response and status
//   dAddr/dDataIn/dRd/dWr         D-port request
//   dDataOut/dDone/dStall/dCacheHit  D-port response and status
//   memAddr/memDataIn/memRd/memWr request toward mem_system
//   memDataOut/memDone/memStall/memCacheHit/memErr  mem_system response
//   err                           combinational protocol/downstream error
module mem_arbiter #(
    parameter int unsigned MAX_CONSEC = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] iAddr,
    input  logic [15:0] iDataIn,
    input  logic        iRd,
    input  logic        iWr,
    output logic [15:0] iDataOut,
    output logic        iDone,
    output logic        iStall,
    output logic        iCacheHit,
    input  logic [15:0] dAddr,
    input  logic [15:0] dDataIn,
    input  logic        dRd,
    input  logic        dWr,
    output logic [15:0] dDataOut,
    output logic        dDone,
    output logic        dStall,
    output logic        dCacheHit,
    output logic [15:0] memAddr,
    output logic [15:0] memDataIn,
    output logic        memRd,
    output logic        memWr,
    input  logic [15:0] memDataOut,
    input  logic        memDone,
    input  logic        memStall,
    input  logic        memCacheHit,
    input  logic        memErr,
    output logic        err
);

    typedef enum logic [1:0] {IDLE, OWN_I, OWN_D} state_t;

    state_t      state_q, state_d;
    logic [3:0]  consec_cnt_q, consec_cnt_d;
    logic [15:0] lat_addr_q, lat_addr_d;
    logic [15:0] lat_data_q, lat_data_d;
    logic        lat_rd_q, lat_rd_d;
    logic        lat_wr_q, lat_wr_d;

    logic        i_req, d_req;
    logic        own_i, own_d;
    logic [15:0] sel_addr, sel_data;
    logic        sel_rd, sel_wr;
    logic        mem_active;

    // memStall carries no extra information beyond memDone for this arbiter
    logic unused_mem_stall;
    assign unused_mem_stall = memStall;

    // State, streak counter and request latch; everything clears on reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            consec_cnt_q <= 4'd0;
            lat_addr_q   <= 16'd0;
            lat_data_q   <= 16'd0;
            lat_rd_q     <= 1'b0;
            lat_wr_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            consec_cnt_q <= consec_cnt_d;
            lat_addr_q   <= lat_addr_d;
            lat_data_q   <= lat_data_d;
            lat_rd_q     <= lat_rd_d;
            lat_wr_q     <= lat_wr_d;
        end
    end

    // Arbitration, next state and every output. In IDLE the winner's live
    // request is routed to mem*; while owned, the latched copy is replayed so
    // the master can no longer disturb the transaction in flight.
    always_comb begin
        i_req        = iRd | iWr;
        d_req        = dRd | dWr;
        state_d      = state_q;
        consec_cnt_d = consec_cnt_q;
        lat_addr_d   = lat_addr_q;
        lat_data_d   = lat_data_q;
        lat_rd_d     = lat_rd_q;
        lat_wr_d     = lat_wr_q;
        own_i        = 1'b0;
        own_d        = 1'b0;
        sel_addr     = 16'd0;
        sel_data     = 16'd0;
        sel_rd       = 1'b0;
        sel_wr       = 1'b0;

        case (state_q)
            IDLE: begin
                // D wins ties until its streak against a waiting I is used up
                if (d_req && !(i_req && consec_cnt_q == 4'(MAX_CONSEC))) begin
                    own_d        = 1'b1;
                    sel_addr     = dAddr;
                    sel_data     = dDataIn;
                    sel_rd       = dRd;
                    sel_wr       = dWr;
                    consec_cnt_d = i_req ? 4'(consec_cnt_q + 4'd1) : 4'd0;
                    if (!memDone) state_d = OWN_D;
                end else if (i_req) begin
                    own_i        = 1'b1;
                    sel_addr     = iAddr;
                    sel_data     = iDataIn;
                    sel_rd       = iRd;
                    sel_wr       = iWr;
                    consec_cnt_d = 4'd0;
                    if (!memDone) state_d = OWN_I;
                end
                if (own_i || own_d) begin
                    lat_addr_d = sel_addr;
                    lat_data_d = sel_data;
                    lat_rd_d   = sel_rd;
                    lat_wr_d   = sel_wr;
                end
            end
            OWN_I, OWN_D: begin
                own_i    = (state_q == OWN_I);
                own_d    = (state_q == OWN_D);
                sel_addr = lat_addr_q;
                sel_data = lat_data_q;
                sel_rd   = lat_rd_q;
                sel_wr   = lat_wr_q;
                if (memDone) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // A simultaneous read+write request is issued as a read only
        memAddr    = sel_addr;
        memDataIn  = sel_data;
        memRd      = sel_rd;
        memWr      = sel_wr & ~sel_rd;
        mem_active = memRd | memWr;

        iDone     = own_i & memDone;
        dDone     = own_d & memDone;
        iDataOut  = iDone ? memDataOut : 16'd0;
        dDataOut  = dDone ? memDataOut : 16'd0;
        iCacheHit = iDone & memCacheHit;
        dCacheHit = dDone & memCacheHit;
        iStall    = i_req & ~iDone;
        dStall    = d_req & ~dDone;

        err = (iRd & iWr) | (dRd & dWr) | memErr | (memDone & ~mem_active)
            | ((state_q == OWN_I) & ~i_req) | ((state_q == OWN_D) & ~d_req);

        // Reset silences every output in the cycle it is asserted
        if (rst) begin
            memAddr   = 16'd0;
            memDataIn = 16'd0;
            memRd     = 1'b0;
            memWr     = 1'b0;
            iDone     = 1'b0;
            dDone     = 1'b0;
            iDataOut  = 16'd0;
            dDataOut  = 16'd0;
            iCacheHit = 1'b0;
            dCacheHit = 1'b0;
            iStall    = 1'b0;
            dStall    = 1'b0;
            err       = 1'b0;
        end
    end

endmodule
